// File: rtl/duty_fader_if.sv
// duty_fader_if: static-level load handshake between software and the fader.
//   load_valid : request to load a static duty level
//   load_duty  : requested static duty (clamped by the fader)
//   load_ready : fader can accept a load this cycle
// Handshake: a load transfers on any clock edge where load_valid && load_ready
// are both high. The requester may present or withdraw a request at will; the
// fader takes no action on load_duty unless the transfer happens.
interface duty_fader_if;
   logic        load_valid;
   logic [31:0] load_duty;
   logic        load_ready;

   modport master (output load_valid, output load_duty, input load_ready);
   modport slave  (input load_valid, input load_duty, output load_ready);
endinterface

// File: rtl/duty_fader.sv
// duty_fader: produces the duty word for the downstream PWM, either a
// breathing ramp (min -> max -> min with a dwell at each extreme) or a
// software-loaded static level. The duty word only changes at period
// boundaries so the PWM never sees a compare change mid-period.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   enable      : breathing enable, acted on at period boundaries
//   step        : duty change per period while ramping
//   hold        : dwell at each extreme in periods (0 behaves as 1)
//   load        : static-level load handshake (slave side)
//   duty        : registered duty word to the PWM
//   period_tick : high in the last cycle of every period
//   state       : current FSM state
module duty_fader #(
   parameter int unsigned PERIOD   = 500000,
   parameter int unsigned DUTY_MIN = 1,
   parameter int unsigned DUTY_MAX = 500000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [31:0] step,
   input  logic [15:0] hold,
   duty_fader_if.slave load,
   output logic [31:0] duty,
   output logic        period_tick,
   output logic [2:0]  state
);

   localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [CW-1:0] LAST  = CW'(PERIOD - 1);
   localparam logic [31:0]   MIN32 = 32'(DUTY_MIN);
   localparam logic [31:0]   MAX32 = 32'(DUTY_MAX);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      RAMP_UP   = 3'd1,
      HOLD_HI   = 3'd2,
      RAMP_DOWN = 3'd3,
      HOLD_LO   = 3'd4,
      STATIC    = 3'd5
   } state_t;

   state_t        st_q, st_d;
   logic [CW-1:0] cnt;
   logic [31:0]   duty_d;
   logic [15:0]   hold_cnt, hold_d;
   logic [31:0]   pending, clamped;
   logic          pend;
   logic          accept;

   // Widened arithmetic so duty+step can never wrap back to a small value.
   logic [32:0]   sum_up;
   logic [32:0]   floor_dn;
   logic [16:0]   hold_nx;
   logic [16:0]   hold_lim;

   assign state       = st_q;
   assign period_tick = (cnt == LAST);
   assign load.load_ready = !reset && !period_tick;
   assign accept      = load.load_valid && load.load_ready;

   assign sum_up   = {1'b0, duty} + {1'b0, step};
   assign floor_dn = {1'b0, MIN32} + {1'b0, step};
   assign hold_nx  = {1'b0, hold_cnt} + 17'd1;
   assign hold_lim = (hold == 16'd0) ? 17'd1 : {1'b0, hold};

   always_comb begin
      clamped = load.load_duty;
      if (load.load_duty < MIN32)
         clamped = MIN32;
      else if (load.load_duty > MAX32)
         clamped = MAX32;
   end

   // Period counter, free-running in lock-step with the PWM counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt <= '0;
      else if (period_tick)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

   // Pending static load. Acceptance is impossible during period_tick, so
   // setting and consuming the pending value never collide on one edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend    <= 1'b0;
         pending <= MIN32;
      end else if (accept) begin
         pend    <= 1'b1;
         pending <= clamped;
      end else if (period_tick) begin
         pend    <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st_q     <= IDLE;
         duty     <= MIN32;
         hold_cnt <= '0;
      end else begin
         st_q     <= st_d;
         duty     <= duty_d;
         hold_cnt <= hold_d;
      end
   end

   always_comb begin
      st_d   = st_q;
      duty_d = duty;
      hold_d = hold_cnt;
      if (period_tick) begin
         if (pend) begin
            st_d   = STATIC;
            duty_d = pending;
            hold_d = '0;
         end else if (!enable && st_q != IDLE && st_q != STATIC) begin
            st_d   = IDLE;
            hold_d = '0;
         end else begin
            case (st_q)
               IDLE: begin
                  if (enable) st_d = RAMP_UP;
               end
               RAMP_UP: begin
                  if (sum_up >= {1'b0, MAX32}) begin
                     duty_d = MAX32;
                     hold_d = '0;
                     st_d   = HOLD_HI;
                  end else begin
                     duty_d = sum_up[31:0];
                  end
               end
               HOLD_HI: begin
                  if (hold_nx >= hold_lim) begin
                     hold_d = '0;
                     st_d   = RAMP_DOWN;
                  end else begin
                     hold_d = hold_nx[15:0];
                  end
               end
               RAMP_DOWN: begin
                  if ({1'b0, duty} <= floor_dn) begin
                     duty_d = MIN32;
                     hold_d = '0;
                     st_d   = HOLD_LO;
                  end else begin
                     duty_d = duty - step;
                  end
               end
               HOLD_LO: begin
                  if (hold_nx >= hold_lim) begin
                     hold_d = '0;
                     st_d   = RAMP_UP;
                  end else begin
                     hold_d = hold_nx[15:0];
                  end
               end
               STATIC: begin
                  if (!enable) st_d = IDLE;
               end
               default: begin
                  st_d   = IDLE;
                  hold_d = '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_duty_fader.sv
// tb_duty_fader: directed bench for duty_fader with PERIOD=10, DUTY_MIN=1,
// DUTY_MAX=10. Expected {state,duty} per boundary is queued by the driver and
// compared by an independent monitor in the first cycle of the new period.
module tb_duty_fader;
   localparam int unsigned P    = 10;
   localparam int unsigned DMIN = 1;
   localparam int unsigned DMAX = 10;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_RU   = 3'd1;
   localparam logic [2:0] S_HH   = 3'd2;
   localparam logic [2:0] S_RD   = 3'd3;
   localparam logic [2:0] S_HL   = 3'd4;
   localparam logic [2:0] S_ST   = 3'd5;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [31:0] step;
   logic [15:0] hold;
   logic [31:0] duty;
   logic        period_tick;
   logic [2:0]  state;

   duty_fader_if lif ();

   duty_fader #(.PERIOD(P), .DUTY_MIN(DMIN), .DUTY_MAX(DMAX)) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .step        (step),
      .hold        (hold),
      .load        (lif.slave),
      .duty        (duty),
      .period_tick (period_tick),
      .state       (state)
   );

   // clock / reset
   always #5 clk = ~clk;

   // scoreboard
   logic [34:0] exp_q[$];
   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // monitor: compares in the first cycle after each boundary
   initial begin : monitor
      logic        tick_d;
      logic [34:0] e;
      tick_d = 1'b0;
      forever begin
         @(negedge clk);
         if (tick_d && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if ({state, duty} !== e) begin
               n_err++;
               $display("FAIL boundary: state=%0d duty=%0d, expected state=%0d duty=%0d",
                        state, duty, e[34:32], e[31:0]);
            end
         end
         tick_d = period_tick;
      end
   end

   // driver tasks
   task automatic wait_tick(input string name);
      int k;
      k = 0;
      while (period_tick !== 1'b1 && k < 2 * P) begin
         @(negedge clk);
         k++;
      end
      if (period_tick !== 1'b1) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s_timeout: no period_tick within %0d cycles", name, 2 * P);
      end
   endtask

   // Queue the expected outcome of the next boundary and run past it.
   task automatic boundary(input logic [2:0] s, input logic [31:0] d);
      exp_q.push_back({s, d});
      wait_tick("boundary");
      @(negedge clk);
   endtask

   // Offer one load for a single cycle; duty must not move on acceptance.
   task automatic do_load(input logic [31:0] v, input logic [31:0] cur_duty);
      lif.load_valid = 1'b1;
      lif.load_duty  = v;
      check("load_ready", {63'd0, lif.load_ready}, 64'd1);
      @(negedge clk);
      lif.load_valid = 1'b0;
      check("duty_on_accept", {32'd0, duty}, {32'd0, cur_duty});
   endtask

   // Offer a load only in the period_tick cycle; it must be refused.
   task automatic tick_load(input logic [2:0] s, input logic [31:0] d);
      exp_q.push_back({s, d});
      wait_tick("tick_load");
      lif.load_valid = 1'b1;
      lif.load_duty  = 32'd2;
      check("load_ready_tick", {63'd0, lif.load_ready}, 64'd0);
      @(negedge clk);
      lif.load_valid = 1'b0;
   endtask

   task automatic report();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
   endtask

   initial begin : watchdog
      #100000;
      n_cmp++;
      n_err++;
      $display("FAIL watchdog: bench did not finish in time");
      report();
      $finish;
   end

   initial begin : stimulus
      reset = 1'b1;
      enable = 1'b0;
      step = 32'd0;
      hold = 16'd0;
      lif.load_valid = 1'b0;
      lif.load_duty  = 32'd0;

      // 1. reset values, then reset mid-run and tick alignment
      repeat (2) @(negedge clk);
      check("rst_duty", {32'd0, duty}, 64'd1);
      check("rst_state", {61'd0, state}, 64'd0);
      check("rst_load_ready", {63'd0, lif.load_ready}, 64'd0);
      check("rst_tick", {63'd0, period_tick}, 64'd0);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      #1;
      check("midrst_duty", {32'd0, duty}, 64'd1);
      check("midrst_state", {61'd0, state}, 64'd0);
      check("midrst_load_ready", {63'd0, lif.load_ready}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      for (int n = 1; n <= 30; n++) begin
         @(negedge clk);
         check($sformatf("tick_c%0d", n), {63'd0, period_tick}, (n % 10 == 9) ? 64'd1 : 64'd0);
         if (n == 1) check("load_ready_after_rst", {63'd0, lif.load_ready}, 64'd1);
      end

      // 2. breathing ramp, step=3 hold=2
      enable = 1'b1;
      step   = 32'd3;
      hold   = 16'd2;
      boundary(S_RU, 1);  boundary(S_RU, 4);  boundary(S_RU, 7);
      boundary(S_HH, 10); boundary(S_HH, 10); boundary(S_RD, 10);
      boundary(S_RD, 7);  boundary(S_RD, 4);  boundary(S_HL, 1);
      boundary(S_HL, 1);  boundary(S_RU, 1);  boundary(S_RU, 4);
      boundary(S_RU, 7);  boundary(S_HH, 10); boundary(S_HH, 10);
      boundary(S_RD, 10); boundary(S_RD, 7);
      // 6a. disable in RAMP_DOWN freezes duty
      enable = 1'b0;
      boundary(S_IDLE, 7);

      // 3. static loads (first one races an enable toggle: load wins)
      enable = 1'b1;
      @(negedge clk);
      do_load(32'd6, 32'd7);
      boundary(S_ST, 6);
      @(negedge clk);
      do_load(32'd0, 32'd6);
      boundary(S_ST, 1);
      @(negedge clk);
      do_load(32'd50, 32'd1);
      boundary(S_ST, 10);
      boundary(S_ST, 10);
      enable = 1'b0;
      boundary(S_IDLE, 10);

      // 4. last load wins; load offered only during period_tick is refused
      @(negedge clk);
      do_load(32'd3, 32'd10);
      @(negedge clk);
      do_load(32'd8, 32'd10);
      boundary(S_ST, 8);
      enable = 1'b1;
      tick_load(S_ST, 8);
      boundary(S_ST, 8);

      // 5. saturation from duty=4 with a huge step
      @(negedge clk);
      do_load(32'd1, 32'd8);
      boundary(S_ST, 1);
      enable = 1'b0;
      boundary(S_IDLE, 1);
      step   = 32'd3;
      enable = 1'b1;
      boundary(S_RU, 1);
      boundary(S_RU, 4);
      step = 32'hFFFF_FFFF;
      boundary(S_HH, 10);
      boundary(S_HH, 10);

      // 6b. async reset mid-period discards a pending load
      repeat (2) @(negedge clk);
      do_load(32'd5, 32'd10);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("rst2_duty", {32'd0, duty}, 64'd1);
      check("rst2_state", {61'd0, state}, 64'd0);
      check("rst2_load_ready", {63'd0, lif.load_ready}, 64'd0);
      check("rst2_tick", {63'd0, period_tick}, 64'd0);
      enable = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      for (int n = 1; n <= 9; n++) begin
         @(negedge clk);
         check($sformatf("rst2_tick_c%0d", n), {63'd0, period_tick}, (n == 9) ? 64'd1 : 64'd0);
      end
      boundary(S_IDLE, 1);

      repeat (2) @(negedge clk);
      check("queue_drained", {32'd0, 32'(exp_q.size())}, 64'd0);
      report();
      $finish;
   end

endmodule
